// File: rtl/mem_arbiter_pkg.sv
// Shared types for the SRAM slot arbiter: owner encoding and the per-requester
// access descriptor.
package mem_arbiter_pkg;

   localparam int unsigned ARB_ADDR_MAX_W = 32;
   localparam int unsigned ARB_STARVE_W   = 4;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_SCR,
      ARB_CPU,
      ARB_DMA
   } arb_owner_t;

   typedef struct packed {
      logic                      we;
      logic [ARB_ADDR_MAX_W-1:0] addr;
      logic [7:0]                wdata;
   } arb_req_t;

endpackage

// File: rtl/mem_arbiter_stats.sv
// Saturating 16-bit count of slot boundaries at which the CPU is held off.
// Present only in builds with MEM_ARB_STATS_EN.
module mem_arbiter_stats (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        inc_i,
   input  logic        clr_i,
   output logic [15:0] count_o
);

   logic [15:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i)
         count_d = '0;
      else if (inc_i && (count_q != '1))
         count_d = count_q + 16'd1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Slot-based arbiter sharing one 8-bit SRAM between screen, CPU and DMA.
// Define MEM_ARB_STATS_EN to add stats_clr / cpu_wait_slots (CPU wait-slot counter).
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = 19,
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic              clk28,
   input  logic              rst,
   input  logic              ck14,
`ifdef MEM_ARB_STATS_EN
   input  logic              stats_clr,
   output logic [15:0]       cpu_wait_slots,
`endif
   input  logic              scr_rd,
   input  logic [ADDR_W-1:0] scr_addr,
   output logic [7:0]        scr_data,
   output logic              scr_valid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_ack,
   output logic              clkwait,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [7:0]        dma_wdata,
   output logic [7:0]        dma_rdata,
   output logic              dma_ack,
   output logic [ADDR_W-1:0] ma,
   output logic [7:0]        md_out,
   output logic              md_oe,
   input  logic [7:0]        md_in,
   output logic              mem_we,
   output logic              mem_oe
);

   localparam logic [ARB_STARVE_W-1:0] STARVE_LIM = ARB_STARVE_W'(STARVE_MAX);

   arb_owner_t              owner_q, owner_d, win_owner;
   arb_req_t                win;
   logic                    cpu_elig, dma_elig;
   logic [ARB_STARVE_W-1:0] starve_q, starve_d;
   logic                    clkwait_q, clkwait_d;
   logic                    we_q;
   logic [ADDR_W-1:0]       ma_q;
   logic [7:0]              md_out_q;
   logic                    mem_oe_q, md_oe_q, mem_we_q;
   logic [7:0]              scr_data_q, cpu_rdata_q, dma_rdata_q;
   logic                    scr_valid_q, cpu_ack_q, dma_ack_q;

   // The owner of the slot now ending is excluded so a held req is not served twice.
   always_comb begin
      cpu_elig  = cpu_req && (owner_q != ARB_CPU);
      dma_elig  = dma_req && (owner_q != ARB_DMA);
      win_owner = ARB_IDLE;
      if (scr_rd)
         win_owner = ARB_SCR;
      else if (dma_elig && (starve_q == STARVE_LIM))
         win_owner = ARB_DMA;
      else if (cpu_elig)
         win_owner = ARB_CPU;
      else if (dma_elig)
         win_owner = ARB_DMA;

      case (win_owner)
         ARB_SCR: win = '{we: 1'b0, addr: ARB_ADDR_MAX_W'(scr_addr), wdata: 8'h00};
         ARB_CPU: win = '{we: cpu_we, addr: ARB_ADDR_MAX_W'(cpu_addr), wdata: cpu_wdata};
         ARB_DMA: win = '{we: dma_we, addr: ARB_ADDR_MAX_W'(dma_addr), wdata: dma_wdata};
         default: win = '0;
      endcase

      owner_d = ck14 ? win_owner : owner_q;

      starve_d = starve_q;
      if (!dma_req)
         starve_d = '0;
      else if (ck14) begin
         if (win_owner == ARB_DMA)
            starve_d = '0;
         else if (dma_elig && (starve_q != STARVE_LIM))
            starve_d = starve_q + 1'b1;
      end

      clkwait_d = clkwait_q;
      if (!cpu_req)
         clkwait_d = 1'b0;
      else if (ck14) begin
         if (win_owner == ARB_CPU)
            clkwait_d = 1'b0;
         else if (cpu_elig)
            clkwait_d = 1'b1;
      end
   end

   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         owner_q     <= ARB_IDLE;
         starve_q    <= '0;
         clkwait_q   <= 1'b0;
         we_q        <= 1'b0;
         ma_q        <= '0;
         md_out_q    <= '0;
         mem_oe_q    <= 1'b0;
         md_oe_q     <= 1'b0;
         mem_we_q    <= 1'b0;
         scr_data_q  <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
         scr_valid_q <= 1'b0;
         cpu_ack_q   <= 1'b0;
         dma_ack_q   <= 1'b0;
      end else begin
         owner_q     <= owner_d;
         starve_q    <= starve_d;
         clkwait_q   <= clkwait_d;
         scr_valid_q <= 1'b0;
         cpu_ack_q   <= 1'b0;
         dma_ack_q   <= 1'b0;
         mem_we_q    <= ~ck14 & we_q;
         if (ck14) begin
            // Close the slot that ends here, then launch the winner's access.
            case (owner_q)
               ARB_SCR: begin
                  scr_data_q  <= md_in;
                  scr_valid_q <= 1'b1;
               end
               ARB_CPU: begin
                  if (!we_q) cpu_rdata_q <= md_in;
                  cpu_ack_q <= 1'b1;
               end
               ARB_DMA: begin
                  if (!we_q) dma_rdata_q <= md_in;
                  dma_ack_q <= 1'b1;
               end
               default: ;
            endcase
            we_q     <= win.we;
            mem_oe_q <= (win_owner != ARB_IDLE) && !win.we;
            md_oe_q  <= win.we;
            if (win_owner != ARB_IDLE) ma_q <= ADDR_W'(win.addr);
            if (win.we) md_out_q <= win.wdata;
         end
      end
   end

`ifdef MEM_ARB_STATS_EN
   mem_arbiter_stats u_stats (
      .clk_i   (clk28),
      .rst_i   (rst),
      .inc_i   (ck14 && clkwait_d),
      .clr_i   (stats_clr),
      .count_o (cpu_wait_slots)
   );
`endif

   assign ma        = ma_q;
   assign md_out    = md_out_q;
   assign md_oe     = md_oe_q;
   assign mem_oe    = mem_oe_q;
   assign mem_we    = mem_we_q;
   assign scr_data  = scr_data_q;
   assign scr_valid = scr_valid_q;
   assign cpu_rdata = cpu_rdata_q;
   assign cpu_ack   = cpu_ack_q;
   assign dma_rdata = dma_rdata_q;
   assign dma_ack   = dma_ack_q;
   assign clkwait   = clkwait_q & cpu_req;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: slot-level reference model plus SRAM model;
// completions are checked by an independent monitor.
module tb_mem_arbiter;

   localparam int STARVE_MAX = 8;

   typedef struct {
      bit         req;
      bit         we;
      logic [18:0] a;
      logic [7:0] d;
   } rq_t;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic        clk28 = 1'b0;
   logic        rst   = 1'b1;
   logic        ck14  = 1'b0;
   logic        scr_rd = 1'b0;
   logic [18:0] scr_addr = '0;
   logic [7:0]  scr_data;
   logic        scr_valid;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [18:0] cpu_addr = '0;
   logic [7:0]  cpu_wdata = '0;
   logic [7:0]  cpu_rdata;
   logic        cpu_ack, clkwait;
   logic        dma_req = 1'b0, dma_we = 1'b0;
   logic [18:0] dma_addr = '0;
   logic [7:0]  dma_wdata = '0;
   logic [7:0]  dma_rdata;
   logic        dma_ack;
   logic [18:0] ma;
   logic [7:0]  md_out;
   logic        md_oe;
   logic [7:0]  md_in = '0;
   logic        mem_we, mem_oe;
`ifdef MEM_ARB_STATS_EN
   logic        stats_clr = 1'b0;
   logic [15:0] cpu_wait_slots;
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   mem_arbiter #(.ADDR_W(19), .STARVE_MAX(STARVE_MAX)) dut (
      .clk28     (clk28),
      .rst       (rst),
      .ck14      (ck14),
`ifdef MEM_ARB_STATS_EN
      .stats_clr      (stats_clr),
      .cpu_wait_slots (cpu_wait_slots),
`endif
      .scr_rd    (scr_rd),
      .scr_addr  (scr_addr),
      .scr_data  (scr_data),
      .scr_valid (scr_valid),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ack   (cpu_ack),
      .clkwait   (clkwait),
      .dma_req   (dma_req),
      .dma_we    (dma_we),
      .dma_addr  (dma_addr),
      .dma_wdata (dma_wdata),
      .dma_rdata (dma_rdata),
      .dma_ack   (dma_ack),
      .ma        (ma),
      .md_out    (md_out),
      .md_oe     (md_oe),
      .md_in     (md_in),
      .mem_we    (mem_we),
      .mem_oe    (mem_oe)
   );

   always #5 clk28 = ~clk28;
   always @(negedge clk28) ck14 <= ~ck14;
   always @(posedge clk28) cyc <= cyc + 1;

   // SRAM contents: physical array written through the pins, reference array by the model.
   logic [7:0] sram    [logic [18:0]];
   logic [7:0] ref_mem [logic [18:0]];

   function automatic logic [7:0] init_val(input logic [18:0] a);
      return a[7:0] ^ {a[14:11], a[18:15]} ^ 8'h5A;
   endfunction

   function automatic logic [7:0] sram_rd(input logic [18:0] a);
      if (sram.exists(a)) return sram[a];
      return init_val(a);
   endfunction

   function automatic logic [7:0] ref_rd(input logic [18:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_val(a);
   endfunction

   always @(negedge clk28) begin
      if (mem_we && md_oe) sram[ma] = md_out;
      md_in = mem_oe ? sram_rd(ma) : 8'h00;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard queues and monitor
   exp_t q_scr[$], q_cpu[$], q_dma[$];

   task automatic got_ack(input string name, input bit have, input exp_t e, input logic [7:0] d);
      chk({name, "_ack_expected"}, 32'(have), 32'd1);
      if (have) begin
         chk({name, "_data"}, 32'(d), 32'(e.data));
         chk({name, "_ack_cycle"}, cyc, e.cyc);
      end
   endtask

   initial begin
      exp_t e;
      bit   have;
      forever begin
         @(negedge clk28);
         if (scr_valid) begin
            have = (q_scr.size() != 0);
            e = '{8'h00, 0};
            if (have) e = q_scr.pop_front();
            got_ack("scr", have, e, scr_data);
         end
         if (cpu_ack) begin
            have = (q_cpu.size() != 0);
            e = '{8'h00, 0};
            if (have) e = q_cpu.pop_front();
            got_ack("cpu", have, e, cpu_rdata);
         end
         if (dma_ack) begin
            have = (q_dma.size() != 0);
            e = '{8'h00, 0};
            if (have) e = q_dma.pop_front();
            got_ack("dma", have, e, dma_rdata);
         end
      end
   end

   // Slot-level reference model state (0 idle, 1 screen, 2 cpu, 3 dma)
   int          m_last = 0;
   int          m_starve = 0;
   bit          m_cw = 0;
   logic [18:0] m_ma = '0;
   logic [7:0]  m_cpu_rd = '0, m_dma_rd = '0;
   int          m_stats = 0;

   task automatic model_reset();
      m_last = 0; m_starve = 0; m_cw = 0; m_ma = '0;
      m_cpu_rd = '0; m_dma_rd = '0; m_stats = 0;
   endtask

   task automatic to_pre_e0();
      while (!ck14) begin
         @(negedge clk28); #1;
      end
   endtask

   // Called just before a slot boundary; runs one whole slot.
   task automatic slot(input bit s, input logic [18:0] sa, input rq_t c, input rq_t d);
      int w;
      bit c_ok, d_ok, wr;
      logic [7:0] wd;
      int now;
      scr_rd = s;     scr_addr = sa;
      cpu_req = c.req; cpu_we = c.we; cpu_addr = c.a; cpu_wdata = c.d;
      dma_req = d.req; dma_we = d.we; dma_addr = d.a; dma_wdata = d.d;
      c_ok = c.req && (m_last != 2);
      d_ok = d.req && (m_last != 3);
      if (s) w = 1;
      else if (d_ok && m_starve == STARVE_MAX) w = 3;
      else if (c_ok) w = 2;
      else if (d_ok) w = 3;
      else w = 0;
      if (!d.req || w == 3) m_starve = 0;
      else if (d_ok && m_starve < STARVE_MAX) m_starve++;
      if (!c.req || w == 2) m_cw = 0;
      else if (c_ok) m_cw = 1;
      now = cyc;
      wr = (w == 2 && c.we) || (w == 3 && d.we);
      wd = (w == 2) ? c.d : d.d;
      case (w)
         1: begin
            m_ma = sa;
            q_scr.push_back('{ref_rd(sa), now + 3});
         end
         2: begin
            m_ma = c.a;
            if (c.we) ref_mem[c.a] = c.d; else m_cpu_rd = ref_rd(c.a);
            q_cpu.push_back('{m_cpu_rd, now + 3});
         end
         3: begin
            m_ma = d.a;
            if (d.we) ref_mem[d.a] = d.d; else m_dma_rd = ref_rd(d.a);
            q_dma.push_back('{m_dma_rd, now + 3});
         end
         default: ;
      endcase
      m_last = w;
`ifdef MEM_ARB_STATS_EN
      if (stats_clr) m_stats = 0;
      else if (m_cw && m_stats != 16'hFFFF) m_stats++;
`endif
      @(posedge clk28); #1;
      chk("clkwait", 32'(clkwait), 32'(m_cw));
      chk("ma", 32'(ma), 32'(m_ma));
      chk("mem_oe", 32'(mem_oe), 32'(w != 0 && !wr));
      chk("md_oe", 32'(md_oe), 32'(wr));
      chk("mem_we_first_cycle", 32'(mem_we), 32'd0);
`ifdef MEM_ARB_STATS_EN
      chk("cpu_wait_slots", 32'(cpu_wait_slots), 32'(m_stats));
`endif
      @(posedge clk28); #1;
      chk("mem_we_second_cycle", 32'(mem_we), 32'(wr));
      if (wr) chk("md_out", 32'(md_out), 32'(wd));
      @(negedge clk28); #1;
      chk("slot_phase", 32'(ck14), 32'd1);
   endtask

   function automatic rq_t rnd_rq();
      rq_t r;
      r.req = 1'b1;
      r.we  = 1'($urandom_range(0, 1));
      r.a   = 19'($urandom_range(0, 31));
      r.d   = 8'($urandom);
      return r;
   endfunction

   initial begin
      rq_t none_rq, cr, dr, cpu_st, dma_st;
      bit  s;
      none_rq = '{1'b0, 1'b0, 19'h0, 8'h00};

      // Reset state
      repeat (3) @(posedge clk28);
      #1;
      chk("rst_ma", 32'(ma), 32'd0);
      chk("rst_md_out", 32'(md_out), 32'd0);
      chk("rst_oe_we", 32'({mem_oe, md_oe, mem_we}), 32'd0);
      chk("rst_acks", 32'({scr_valid, cpu_ack, dma_ack, clkwait}), 32'd0);
      chk("rst_rdata", 32'({scr_data, cpu_rdata, dma_rdata}), 32'd0);
      @(negedge clk28); #1;
      rst = 1'b0;
      to_pre_e0();

      // Uncontended CPU read
      sram[19'h05A00] = 8'h3C;
      ref_mem[19'h05A00] = 8'h3C;
      cr = '{1'b1, 1'b0, 19'h05A00, 8'h00};
      slot(0, '0, cr, none_rq);
      slot(0, '0, cr, none_rq);
      slot(0, '0, none_rq, none_rq);

      // Screen and CPU collide: screen first, CPU stalled then served
      cr = '{1'b1, 1'b0, 19'h00012, 8'h00};
      slot(1, 19'h01234, cr, none_rq);
      slot(0, '0, cr, none_rq);
      slot(0, '0, cr, none_rq);
      slot(0, '0, none_rq, none_rq);

      // CPU and DMA held: alternating slots, then screen on even slots forces DMA in
      cr = '{1'b1, 1'b0, 19'h00020, 8'h00};
      dr = '{1'b1, 1'b0, 19'h00021, 8'h00};
      for (int i = 0; i < 6; i++) slot(0, '0, cr, dr);
      for (int i = 0; i < 24; i++) slot(i % 2 == 0, 19'(i), cr, dr);
      slot(0, '0, none_rq, none_rq);
      slot(0, '0, none_rq, none_rq);

      // DMA write to the top address, read back by the CPU
      dr = '{1'b1, 1'b1, 19'h7FFFF, 8'hA5};
      slot(0, '0, none_rq, dr);
      slot(0, '0, none_rq, none_rq);
      cr = '{1'b1, 1'b0, 19'h7FFFF, 8'h00};
      slot(0, '0, cr, none_rq);
      slot(0, '0, none_rq, none_rq);
      slot(0, '0, none_rq, none_rq);

      // Reset in the middle of a CPU write slot; held request is served afterwards
      cr = '{1'b1, 1'b1, 19'h00011, 8'h5E};
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = cr.a; cpu_wdata = cr.d;
      @(posedge clk28); #1;
      chk("rstmid_md_oe_before", 32'(md_oe), 32'd1);
      @(posedge clk28); #1;
      chk("rstmid_mem_we_before", 32'(mem_we), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstmid_mem_we", 32'(mem_we), 32'd0);
      chk("rstmid_md_oe", 32'(md_oe), 32'd0);
      chk("rstmid_clkwait", 32'(clkwait), 32'd0);
      chk("rstmid_ma", 32'(ma), 32'd0);
      model_reset();
      @(negedge clk28); #1;
      rst = 1'b0;
      to_pre_e0();
      slot(0, '0, cr, none_rq);
      slot(0, '0, cr, none_rq);
      slot(0, '0, none_rq, none_rq);

`ifdef MEM_ARB_STATS_EN
      cr = '{1'b1, 1'b0, 19'h00031, 8'h00};
      stats_clr = 1'b1;
      slot(0, '0, none_rq, none_rq);
      stats_clr = 1'b0;
      for (int i = 0; i < 5; i++) slot(1, 19'(32 + i), cr, none_rq);
      chk("stats_five", 32'(cpu_wait_slots), 32'd5);
      stats_clr = 1'b1;
      slot(1, 19'h00040, cr, none_rq);
      stats_clr = 1'b0;
      chk("stats_clr_wins", 32'(cpu_wait_slots), 32'd0);
      slot(0, '0, cr, none_rq);
      slot(0, '0, cr, none_rq);
      slot(0, '0, none_rq, none_rq);
`endif

      // Randomised traffic with held requests, drops before and after grant
      cpu_st = none_rq;
      dma_st = none_rq;
      for (int i = 0; i < 160; i++) begin
         s = ($urandom_range(0, 9) < 4);
         if (cpu_st.req && m_last == 2) begin
            cr = cpu_st;
            if ($urandom_range(0, 1) == 1) cr.req = 1'b0;
            cpu_st.req = 1'b0;
         end else if (cpu_st.req) begin
            if ($urandom_range(0, 15) == 0) cpu_st.req = 1'b0;
            cr = cpu_st;
         end else begin
            if ($urandom_range(0, 1) == 1) cpu_st = rnd_rq();
            cr = cpu_st;
         end
         if (dma_st.req && m_last == 3) begin
            dr = dma_st;
            if ($urandom_range(0, 1) == 1) dr.req = 1'b0;
            dma_st.req = 1'b0;
         end else if (dma_st.req) begin
            if ($urandom_range(0, 15) == 0) dma_st.req = 1'b0;
            dr = dma_st;
         end else begin
            if ($urandom_range(0, 2) == 0) dma_st = rnd_rq();
            dr = dma_st;
         end
         slot(s, 19'($urandom_range(0, 31)), cr, dr);
      end
      repeat (3) slot(0, '0, none_rq, none_rq);

      chk("scr_queue_drained", q_scr.size(), 0);
      chk("cpu_queue_drained", q_cpu.size(), 0);
      chk("dma_queue_drained", q_dma.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
